pong_score_ctl: RTL

PONG_SCORE_CTL -- requirements
Module: pong_score_ctl

---
 rtl/pong_score_ctl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pong_score_ctl.sv
// rtl/pong_score_ctl.sv - Pong score keeper: rally FSM, miss detection, scores, game over
// Optional feature macro: SCORE_AUTO_SERVE_EN (auto-serve after SERVE_DELAY clocks in POINT)
module pong_score_ctl #(
    parameter int GAME_WIDTH    = 40,
    parameter int GAME_HEIGHT   = 30,
    parameter int PADDLE_HEIGHT = 6,
    parameter int SCORE_LIMIT   = 9,
    parameter int SERVE_DELAY   = 25000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       Start_i,
    input  logic [5:0] Ball_X_i,
    input  logic [5:0] Ball_Y_i,
    input  logic [5:0] Paddle_Y_P1_i,
    input  logic [5:0] Paddle_Y_P2_i,
    output logic       Game_Active_o,
    output logic [3:0] P1_Score_o,
    output logic [3:0] P2_Score_o,
    output logic       Game_Over_o,
    output logic       Winner_o
);

    // Reject parameter sets the 6-bit coordinates and 4-bit scores cannot represent.
    if (GAME_WIDTH < 2 || GAME_WIDTH > 64 || GAME_HEIGHT < 1 || GAME_HEIGHT > 64 ||
        PADDLE_HEIGHT < 1 || SCORE_LIMIT < 1 || SCORE_LIMIT > 15 || SERVE_DELAY < 1) begin : g_bad_params
        $error("pong_score_ctl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_POINT,
        S_GAME_OVER
    } state_t;

    localparam logic [5:0] RIGHT_COL = 6'(GAME_WIDTH - 1);
    localparam logic [6:0] PAD_LEN   = 7'(PADDLE_HEIGHT);
    localparam logic [3:0] LIMIT     = 4'(SCORE_LIMIT);

    state_t     state_q;
    logic [5:0] x_prev_q;
    logic [3:0] p1_q;
    logic [3:0] p2_q;
    logic       active_q;
    logic       over_q;
    logic       winner_q;
    // High on the first POINT cycle, where Start_i is not yet honoured.
    logic       point_first_q;

`ifdef SCORE_AUTO_SERVE_EN
    localparam int CNT_W = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
    logic [CNT_W-1:0] serve_cnt_q;
`endif

    logic       arrival_left;
    logic       arrival_right;
    logic       cover_p1;
    logic       cover_p2;
    logic       miss_left;
    logic       miss_right;
    logic [3:0] p1_inc_d;
    logic [3:0] p2_inc_d;

    // An arrival is the first sample on a paddle column, so dwelling there scores once.
    assign arrival_left  = (Ball_X_i == 6'd0) && (x_prev_q != 6'd0);
    assign arrival_right = (Ball_X_i == RIGHT_COL) && (x_prev_q != RIGHT_COL);

    // Cover window is computed 7 bits wide so a paddle near row 63 cannot wrap.
    assign cover_p1 = ({1'b0, Paddle_Y_P1_i} <= {1'b0, Ball_Y_i}) &&
                      ({1'b0, Ball_Y_i} < ({1'b0, Paddle_Y_P1_i} + PAD_LEN));
    assign cover_p2 = ({1'b0, Paddle_Y_P2_i} <= {1'b0, Ball_Y_i}) &&
                      ({1'b0, Ball_Y_i} < ({1'b0, Paddle_Y_P2_i} + PAD_LEN));

    assign miss_left  = arrival_left && !cover_p1;
    assign miss_right = arrival_right && !cover_p2;

    // Saturating increments.
    assign p1_inc_d = (p1_q == 4'd15) ? 4'd15 : p1_q + 4'd1;
    assign p2_inc_d = (p2_q == 4'd15) ? 4'd15 : p2_q + 4'd1;

    // Game FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            x_prev_q      <= 6'd0;
            p1_q          <= 4'd0;
            p2_q          <= 4'd0;
            active_q      <= 1'b0;
            over_q        <= 1'b0;
            winner_q      <= 1'b0;
            point_first_q <= 1'b0;
`ifdef SCORE_AUTO_SERVE_EN
            serve_cnt_q   <= '0;
`endif
        end else begin
            x_prev_q <= Ball_X_i;
            case (state_q)
                S_IDLE: begin
                    if (Start_i) begin
                        state_q  <= S_RUNNING;
                        active_q <= 1'b1;
                    end
                end
                S_RUNNING: begin
                    if (miss_left) begin
                        p2_q     <= p2_inc_d;
                        active_q <= 1'b0;
                        if (p2_inc_d == LIMIT) begin
                            state_q  <= S_GAME_OVER;
                            over_q   <= 1'b1;
                            winner_q <= 1'b1;
                        end else begin
                            state_q       <= S_POINT;
                            point_first_q <= 1'b1;
                        end
                    end else if (miss_right) begin
                        p1_q     <= p1_inc_d;
                        active_q <= 1'b0;
                        if (p1_inc_d == LIMIT) begin
                            state_q  <= S_GAME_OVER;
                            over_q   <= 1'b1;
                            winner_q <= 1'b0;
                        end else begin
                            state_q       <= S_POINT;
                            point_first_q <= 1'b1;
                        end
                    end
                end
                S_POINT: begin
                    point_first_q <= 1'b0;
`ifdef SCORE_AUTO_SERVE_EN
                    if ((!point_first_q && Start_i) || (serve_cnt_q == CNT_LAST)) begin
                        state_q     <= S_RUNNING;
                        active_q    <= 1'b1;
                        serve_cnt_q <= '0;
                    end else begin
                        serve_cnt_q <= serve_cnt_q + 1'b1;
                    end
`else
                    if (!point_first_q && Start_i) begin
                        state_q  <= S_RUNNING;
                        active_q <= 1'b1;
                    end
`endif
                end
                S_GAME_OVER: begin
                    if (Start_i) begin
                        state_q  <= S_RUNNING;
                        active_q <= 1'b1;
                        over_q   <= 1'b0;
                        winner_q <= 1'b0;
                        p1_q     <= 4'd0;
                        p2_q     <= 4'd0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Game_Active_o = active_q;
    assign P1_Score_o    = p1_q;
    assign P2_Score_o    = p2_q;
    assign Game_Over_o   = over_q;
    assign Winner_o      = winner_q;

endmodule
